spi_master_seq: RTL

SPI_MASTER_SEQ -- requirements
Module: spi_master_seq

---
 rtl/spi_pkg.sv | 39 +++
 rtl/spi_master_seq_if.sv | 27 ++
 rtl/spi_frame_shifter.sv | 59 +++++
 rtl/spi_master_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_pkg
// Brief   : Command codes, FSM state encoding and counter sizing shared by the
//           spi_master_seq top and its frame shifter.
// Rev     : 1.0  initial release
// ============================================================================
package spi_pkg;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef logic [2:0] spi_state_t;
   localparam spi_state_t ST_IDLE  = 3'd0;
   localparam spi_state_t ST_SEL   = 3'd1;
   localparam spi_state_t ST_SHIFT = 3'd2;
   localparam spi_state_t ST_TURN  = 3'd3;
   localparam spi_state_t ST_RECV  = 3'd4;
   localparam spi_state_t ST_GAP   = 3'd5;

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(9);
   localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(7);

   function automatic logic [1:0] frame_cmd(input logic rd, input logic data_frame);
      logic [1:0] cmd;
      case ({rd, data_frame})
         2'b00:   cmd = CMD_WR_ADDR;
         2'b01:   cmd = CMD_WR_DATA;
         2'b10:   cmd = CMD_RD_ADDR;
         default: cmd = CMD_RD_DATA;
      endcase
      return cmd;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_master_seq_if
// Brief   : Host request/response bundle of spi_master_seq.
// Rev     : 1.0  initial release
// ============================================================================
interface spi_master_seq_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_rd;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       busy;

   modport master (
      output req_valid, req_rd, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, busy
   );

   modport slave (
      input  req_valid, req_rd, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, busy
   );
endinterface
`default_nettype wire

// File: rtl/spi_frame_shifter.sv
`default_nettype none
// ============================================================================
// Module  : spi_frame_shifter
// Brief   : 10-bit MOSI shift register, 8-bit MISO shift register and the
//           per-state cycle counter, sequenced by spi_master_seq.
// Rev     : 1.0  initial release
// ============================================================================
module spi_frame_shifter
   import spi_pkg::*;
(
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_load,
   input  wire logic [9:0]       i_payload,
   input  wire logic             i_shift,
   input  wire logic             i_recv,
   input  wire logic             i_miso,
   input  wire logic             i_cnt_clr,
   output logic                  o_mosi_bit,
   output logic [CNT_W-1:0]      o_cnt,
   output logic [7:0]            o_rx_next
);

   logic [9:0]       r_tx;
   logic [7:0]       r_rx;
   logic [CNT_W-1:0] r_cnt;

   // Next receive value is exported so the top can capture the byte on the
   // same edge as the last sample.
   assign o_rx_next  = {r_rx[6:0], i_miso};
   assign o_mosi_bit = r_tx[9];
   assign o_cnt      = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx  <= '0;
         r_rx  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_load) begin
            r_tx <= i_payload;
         end else if (i_shift) begin
            r_tx <= {r_tx[8:0], 1'b0};
         end

         if (i_recv) begin
            r_rx <= o_rx_next;
         end

         if (i_cnt_clr) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_master_seq.sv
`default_nettype none
// ============================================================================
// Module  : spi_master_seq
// Brief   : Host-request to two-frame SPI memory transaction sequencer.
//           Optional SPI_MASTER_ADDR_SKIP_EN skips a repeated address frame.
// Rev     : 1.0  initial release
// ============================================================================
module spi_master_seq
   import spi_pkg::*;
#(
   parameter int TURN_CYCLES = 2,
   parameter int GAP_CYCLES  = 1
)(
   input  wire logic          clk,
   input  wire logic          rst_n,
   spi_master_seq_if.slave    bus,
   output logic               SS_n,
   output logic               MOSI,
   input  wire logic          MISO
);

   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES  > 0) ? GAP_CYCLES  - 1 : 0);

   spi_state_t       r_state;
   spi_state_t       w_next_state;
   logic             r_ready_en;
   logic             r_rd;
   logic [7:0]       r_addr;
   logic [7:0]       r_wdata;
   logic             r_data_frame;
   logic             r_rsp_valid;
   logic [7:0]       r_rsp_rdata;

   logic             w_req_ready;
   logic             w_busy;
   logic             w_accept;
   logic             w_skip;
   logic [9:0]       w_payload;
   logic             w_load;
   logic             w_shift;
   logic             w_recv;
   logic             w_cnt_clr;
   logic             w_tx_bit;
   logic [CNT_W-1:0] w_cnt;
   logic [7:0]       w_rx_next;

   assign w_accept  = bus.req_valid && w_req_ready;
   assign w_payload = {frame_cmd(r_rd, r_data_frame),
                       r_data_frame ? (r_rd ? 8'h00 : r_wdata) : r_addr};

   assign bus.req_ready = w_req_ready;
   assign bus.busy      = w_busy;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;

   spi_frame_shifter u_shifter (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_payload  (w_payload),
      .i_shift    (w_shift),
      .i_recv     (w_recv),
      .i_miso     (MISO),
      .i_cnt_clr  (w_cnt_clr),
      .o_mosi_bit (w_tx_bit),
      .o_cnt      (w_cnt),
      .o_rx_next  (w_rx_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_next_state = ST_SEL;
         end
         ST_SEL: begin
            w_next_state = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (w_cnt == SHIFT_LAST) begin
               if (r_data_frame && r_rd) begin
                  w_next_state = (TURN_CYCLES > 0) ? ST_TURN : ST_RECV;
               end else begin
                  w_next_state = ST_GAP;
               end
            end
         end
         ST_TURN: begin
            if (w_cnt == TURN_LAST) w_next_state = ST_RECV;
         end
         ST_RECV: begin
            if (w_cnt == RECV_LAST) w_next_state = ST_GAP;
         end
         ST_GAP: begin
            if (w_cnt == GAP_LAST) w_next_state = r_data_frame ? ST_IDLE : ST_SEL;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      SS_n        = 1'b1;
      MOSI        = 1'b0;
      w_busy      = (r_state != ST_IDLE);
      w_req_ready = r_ready_en && (r_state == ST_IDLE);
      w_load      = (r_state == ST_SEL);
      w_shift     = (r_state == ST_SHIFT);
      w_recv      = (r_state == ST_RECV);
      w_cnt_clr   = (w_next_state != r_state);
      case (r_state)
         ST_SEL: begin
            SS_n = 1'b0;
            MOSI = w_payload[9];
         end
         ST_SHIFT: begin
            SS_n = 1'b0;
            MOSI = w_tx_bit;
         end
         ST_TURN, ST_RECV: begin
            SS_n = 1'b0;
         end
         default: begin
            SS_n = 1'b1;
         end
      endcase
   end

   // Ready is held off until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready_en   <= 1'b0;
         r_rd         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_data_frame <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_rdata  <= '0;
      end else begin
         r_ready_en  <= 1'b1;
         r_rsp_valid <= (r_state == ST_RECV) && (w_cnt == RECV_LAST);
         if ((r_state == ST_RECV) && (w_cnt == RECV_LAST)) begin
            r_rsp_rdata <= w_rx_next;
         end
         if (w_accept) begin
            r_rd         <= bus.req_rd;
            r_addr       <= bus.req_addr;
            r_wdata      <= bus.req_wdata;
            r_data_frame <= w_skip;
         end else if ((r_state == ST_GAP) && (w_cnt == GAP_LAST)) begin
            r_data_frame <= 1'b1;
         end
      end
   end

`ifdef SPI_MASTER_ADDR_SKIP_EN
   logic       r_wr_addr_vld;
   logic [7:0] r_wr_addr;
   logic       r_rd_addr_vld;
   logic [7:0] r_rd_addr;

   assign w_skip = bus.req_rd ? (r_rd_addr_vld && (bus.req_addr == r_rd_addr))
                              : (r_wr_addr_vld && (bus.req_addr == r_wr_addr));

   // The cached address becomes valid once its address frame has been shifted out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_addr_vld <= 1'b0;
         r_wr_addr     <= '0;
         r_rd_addr_vld <= 1'b0;
         r_rd_addr     <= '0;
      end else if ((r_state == ST_SHIFT) && (w_cnt == SHIFT_LAST) && !r_data_frame) begin
         if (r_rd) begin
            r_rd_addr_vld <= 1'b1;
            r_rd_addr     <= r_addr;
         end else begin
            r_wr_addr_vld <= 1'b1;
            r_wr_addr     <= r_addr;
         end
      end
   end
`else
   assign w_skip = 1'b0;
`endif

endmodule
`default_nettype wire
